// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states,
// instruction field positions and the immediate sign-extension helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2
  } state_t;

  // Instruction field bit positions (MIPS I-/R-type layout)
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory read handshake on one side and the
// held-instruction valid/ready handshake plus decoded fields on the other.
interface fetch_if;
  // instruction memory side
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  // downstream side
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic        pc_load_i;
  logic [31:0] instr_o;
  logic [5:0]  opcode_o;
  logic [4:0]  rs_o;
  logic [4:0]  rt_o;
  logic [4:0]  rd_o;
  logic [5:0]  funct_o;
  logic [31:0] imm_o;
  logic [31:0] pc_o;

  // master: the fetch stage itself
  modport master (
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, opcode_o,
           rs_o, rt_o, rd_o, funct_o, imm_o, pc_o,
    input  imem_ack_i, imem_data_i, instr_ready_i, pc_load_i
  );

  // slave: memory + control/datapath environment
  modport slave (
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, opcode_o,
           rs_o, rt_o, rd_o, funct_o, imm_o, pc_o,
    output imem_ack_i, imem_data_i, instr_ready_i, pc_load_i
  );
endinterface

// File: rtl/fetch_branch_target.sv
// Next-PC computation: sequential PC+4, or PC+4 plus the word-scaled
// sign-extended immediate when the branch is taken. Purely combinational,
// wraps modulo 2^32, result always word aligned.
module branch_target (
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic        pc_load,
  output logic [31:0] next_pc
);

  logic [31:0] offset;
  logic [31:0] sum;

  // Select branch offset and force the result onto a word boundary
  always_comb begin
    offset  = pc_load ? {imm[29:0], 2'b00} : 32'd0;
    sum     = pc + 32'd4 + offset;
    next_pc = sum & 32'hFFFF_FFFC;
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: PC register, req/ack instruction read, and an
// instruction register exposed downstream through valid/ready with its
// decoded fields. The branch decision is applied when the held word retires.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic clk_i,
  input  logic rst_ni,
  fetch_if.master bus
);

  state_t      state, state_nxt;
  logic [31:0] pc;        // address being / last fetched
  logic [31:0] ir;        // instruction register
  logic [31:0] pc_held;   // address of the word in ir
  logic [31:0] imm;
  logic [31:0] next_pc;
  logic        take_ack;
  logic        retire;

  assign take_ack = (state == S_REQ)   && bus.imem_ack_i;
  assign retire   = (state == S_VALID) && bus.instr_ready_i;
  assign imm      = sext16(ir[IMM_MSB:IMM_LSB]);

  branch_target u_bt (
    .pc      (pc),
    .imm     (imm),
    .pc_load (bus.pc_load_i),
    .next_pc (next_pc)
  );

  // State register; reset abandons any outstanding request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic: IDLE -> REQ -> (ack) VALID -> (retire) REQ
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_REQ;
      S_REQ:   if (bus.imem_ack_i)    state_nxt = S_VALID;
      S_VALID: if (bus.instr_ready_i) state_nxt = S_REQ;
      default: state_nxt = S_IDLE;
    endcase
  end

  // PC / IR / held-PC registers; IR frozen outside the ack cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc      <= RESET_PC;
      ir      <= 32'd0;
      pc_held <= RESET_PC;
    end else begin
      if (take_ack) begin
        ir      <= bus.imem_data_i;
        pc_held <= pc;
      end
      if (retire) pc <= next_pc;
    end
  end

  // Handshake outputs are pure state decodes
  assign bus.imem_req_o    = (state == S_REQ);
  assign bus.instr_valid_o = (state == S_VALID);
  assign bus.imem_addr_o   = pc;

  // Decoded fields are plain slices of the IR
  assign bus.instr_o  = ir;
  assign bus.opcode_o = ir[OPCODE_MSB:OPCODE_LSB];
  assign bus.rs_o     = ir[RS_MSB:RS_LSB];
  assign bus.rt_o     = ir[RT_MSB:RT_LSB];
  assign bus.rd_o     = ir[RD_MSB:RD_LSB];
  assign bus.funct_o  = ir[FUNCT_MSB:FUNCT_LSB];
  assign bus.imm_o    = imm;
  assign bus.pc_o     = pc_held;

endmodule
